// File: rtl/serial_reg_file_mc_if.sv
// Serial register file bus: strobes, serial data, status, and the parallel register view.
//   master : config master / datapath side (drives strobes, din, stat_d)
//   slave  : register file side (drives dout, busy, err, reg_q)
interface serial_reg_file_mc_if #(
  parameter int unsigned N_REG      = 5,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                          wr_en;
  logic                          rd_en;
  logic                          din;
  logic                          dout;
  logic                          busy;
  logic                          err;
  logic [N_REG*DATA_WIDTH-1:0]   reg_q;
  logic [N_REG*DATA_WIDTH-1:0]   stat_d;

  modport master (
    output wr_en, rd_en, din, stat_d,
    input  dout, busy, err, reg_q
  );

  modport slave (
    input  wr_en, rd_en, din, stat_d,
    output dout, busy, err, reg_q
  );
endinterface

// File: rtl/serial_reg_file_mc.sv
// Serial-access register file: N_REG registers behind a 1-bit MSB-first port,
// with per-register reset values, read-only status capture, miss/protocol error
// pulses, a busy flag and a parallel register view.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : serial_reg_file_mc_if.slave (wr_en, rd_en, din, dout, busy, err, reg_q, stat_d)
module serial_reg_file_mc #(
  parameter int unsigned                   N_REG      = 5,
  parameter int unsigned                   ADDR_WIDTH = 8,
  parameter int unsigned                   DATA_WIDTH = 8,
  parameter logic [N_REG*ADDR_WIDTH-1:0]   ADDR_TABLE = 40'h55_06_A1_78_34,
  parameter logic [N_REG*DATA_WIDTH-1:0]   RST_VALUES = '0,
  parameter logic [N_REG-1:0]              RO_MASK    = 5'b10000
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  serial_reg_file_mc_if.slave  bus
);

  localparam int unsigned A       = ADDR_WIDTH;
  localparam int unsigned D       = DATA_WIDTH;
  localparam int unsigned CNT_MAX = (A > D) ? A : D;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned IDX_W   = (N_REG > 1) ? $clog2(N_REG) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_TURN, S_RDATA} state_t;

  // Address table must decode uniquely.
  function automatic bit f_addrs_distinct();
    for (int i = 0; i < N_REG; i++)
      for (int j = i + 1; j < N_REG; j++)
        if (ADDR_TABLE[i*A +: A] == ADDR_TABLE[j*A +: A]) return 1'b0;
    return 1'b1;
  endfunction

  if (!f_addrs_distinct()) begin : g_addr_dup
    $error("serial_reg_file_mc: ADDR_TABLE entries are not distinct");
  end

  state_t             r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_is_wr, w_is_wr_nxt;
  logic [A-1:0]       r_addr, w_addr_nxt;
  logic               r_hit, w_hit_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [D-1:0]       r_shift, w_shift_nxt;
  logic               r_dout, w_dout_nxt;
  logic               r_busy;
  logic               r_err, w_err_nxt;
  logic               r_ign, w_ign_nxt;
  logic               w_we;

  logic               w_strobe, w_last, w_accept;
  logic [A-1:0]       w_addr_full;
  logic [D-1:0]       w_data_full;
  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic [D-1:0]       w_rd_val;
  logic [D-1:0]       w_regs [N_REG];
  logic [N_REG*D-1:0] w_reg_q;

  assign w_strobe    = bus.wr_en | bus.rd_en;
  assign w_last      = ((r_state == S_WDATA) || (r_state == S_RDATA)) && (r_cnt == '0);
  // A strobe is taken in IDLE or on the final edge of a frame (back-to-back).
  assign w_accept    = w_strobe && ((r_state == S_IDLE) || w_last);
  assign w_addr_full = A'({r_addr, bus.din});
  assign w_data_full = D'({r_shift, bus.din});

  // Address decode and read-source mux for the completed address.
  always_comb begin
    w_hit    = 1'b0;
    w_idx    = '0;
    w_rd_val = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (ADDR_TABLE[i*A +: A] == w_addr_full) begin
        w_hit    = 1'b1;
        w_idx    = IDX_W'(i);
        w_rd_val = RO_MASK[i] ? bus.stat_d[i*D +: D] : w_regs[i];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_strobe) w_next_state = S_ADDR;
      S_ADDR:  if (r_cnt == '0) w_next_state = r_is_wr ? S_WDATA : S_TURN;
      S_WDATA,
      S_RDATA: if (r_cnt == '0) w_next_state = w_strobe ? S_ADDR : S_IDLE;
      S_TURN:  w_next_state = S_RDATA;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_is_wr_nxt = r_is_wr;
    w_addr_nxt  = r_addr;
    w_hit_nxt   = r_hit;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_dout_nxt  = 1'b0;
    w_err_nxt   = r_ign;
    w_ign_nxt   = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      S_ADDR: begin
        w_addr_nxt = w_addr_full;
        if (r_cnt == '0) begin
          w_hit_nxt   = w_hit;
          w_idx_nxt   = w_idx;
          // Read source captured here; a miss shifts out zeros.
          w_shift_nxt = w_hit ? w_rd_val : '0;
          w_cnt_nxt   = CNT_W'(D - 1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_WDATA: begin
        w_shift_nxt = w_data_full;
        if (r_cnt == '0) begin
          w_we = r_hit && !RO_MASK[r_idx];
          if (!r_hit) w_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_TURN: begin
        w_dout_nxt  = r_shift[D-1];
        w_shift_nxt = r_shift << 1;
        w_cnt_nxt   = CNT_W'(D - 1);
        if (!r_hit) w_err_nxt = 1'b1;
      end
      S_RDATA: begin
        if (r_cnt != '0) begin
          w_dout_nxt  = r_shift[D-1];
          w_shift_nxt = r_shift << 1;
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: ;
    endcase
    if (w_accept) begin
      w_cnt_nxt   = CNT_W'(A - 1);
      w_is_wr_nxt = bus.wr_en;
      w_ign_nxt   = bus.wr_en & bus.rd_en;   // write wins, read dropped
    end else if (w_strobe && (r_state != S_IDLE)) begin
      w_ign_nxt = 1'b1;                      // strobe mid-frame
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_addr  <= '0;
      r_hit   <= 1'b0;
      r_idx   <= '0;
      r_shift <= '0;
      r_dout  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_ign   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_is_wr <= w_is_wr_nxt;
      r_addr  <= w_addr_nxt;
      r_hit   <= w_hit_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_dout  <= w_dout_nxt;
      r_busy  <= (w_next_state != S_IDLE);
      r_err   <= w_err_nxt;
      r_ign   <= w_ign_nxt;
    end
  end

  // Register storage: RO entries have no storage and read as zero in the view.
  for (genvar gi = 0; gi < N_REG; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign w_regs[gi] = '0;
    end else begin : g_rw
      logic [D-1:0] r_val;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                               r_val <= RST_VALUES[gi*D +: D];
        else if (w_we && (r_idx == IDX_W'(gi)))     r_val <= w_data_full;
      end
      assign w_regs[gi] = r_val;
    end
  end

  always_comb begin
    w_reg_q = '0;
    for (int i = 0; i < N_REG; i++) w_reg_q[i*D +: D] = w_regs[i];
  end

  assign bus.reg_q = w_reg_q;
  assign bus.dout  = r_dout;
  assign bus.busy  = r_busy;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_serial_reg_file_mc.sv
// Directed bench for serial_reg_file_mc with a read-data scoreboard and an ERR pulse monitor.
module tb_serial_reg_file_mc;
  localparam int unsigned A = 8;
  localparam int unsigned D = 8;
  localparam int unsigned N = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_reg_file_mc_if #(.N_REG(N), .DATA_WIDTH(D)) bus_if ();
  serial_reg_file_mc u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_if));

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int err_cnt = 0;
  int last_err_cyc = -1;

  logic [7:0] m_regs [N];
  logic [7:0] tab [N] = '{8'h34, 8'h78, 8'hA1, 8'h06, 8'h55};
  bit         ro  [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus_if.err === 1'b1) begin err_cnt++; last_err_cyc = cyc; end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [7:0] a);
    for (int i = 0; i < N; i++) if (tab[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [39:0] model_q();
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = ro[i] ? 8'h00 : m_regs[i];
    return r;
  endfunction

  // Strobes for upcoming edge C0+e: optional injected WR_EN, optional back-to-back strobe at L.
  task automatic strobes(input int e, input int lrel, input int nxt, input int inj);
    bus_if.wr_en = (e == inj) || (e == lrel && nxt == 1);
    bus_if.rd_en = (e == lrel && nxt == 2);
  endtask

  // One frame. pre=1: strobe already accepted at the previous frame's L. nxt: 0 none, 1 write, 2 read at L.
  task automatic frame(input bit is_wr, input logic [7:0] addr, input logic [7:0] data,
                       input bit pre, input int nxt, input int inj, input bit both, output int c0);
    int lrel;
    int ix;
    logic [7:0] got;
    lrel = is_wr ? int'(A + D) : int'(A + D + 1);
    ix = idx_of(addr);
    got = '0;
    if (!pre) begin
      bus_if.wr_en = is_wr;
      bus_if.rd_en = !is_wr || both;
      step();
    end
    c0 = cyc;
    chk("busy_at_c0", 64'(bus_if.busy), 64'(1));
    if (!is_wr) exp_q.push_back(ix < 0 ? 8'h00 : (ro[ix] ? bus_if.stat_d[ix*8 +: 8] : m_regs[ix]));
    for (int k = A - 1; k >= 0; k--) begin
      bus_if.din = addr[k];
      strobes(int'(A) - k, lrel, nxt, inj);
      step();
    end
    if (is_wr) begin
      for (int k = D - 1; k >= 0; k--) begin
        bus_if.din = data[k];
        strobes(int'(A + D) - k, lrel, nxt, inj);
        if (k == 0) chk("regq_before_L", 64'(bus_if.reg_q), 64'(model_q()));
        step();
      end
      if (ix >= 0 && !ro[ix]) m_regs[ix] = data;
      chk("regq_at_L", 64'(bus_if.reg_q), 64'(model_q()));
      chk("busy_at_L", 64'(bus_if.busy), 64'(nxt != 0));
    end else begin
      for (int k = 0; k < D; k++) begin
        strobes(int'(A) + 1 + k, lrel, nxt, inj);
        step();
        got[D-1-k] = bus_if.dout;
      end
      strobes(lrel, lrel, nxt, inj);
      step();
      chk("dout_zero_at_L", 64'(bus_if.dout), 64'(0));
      chk("busy_at_L", 64'(bus_if.busy), 64'(nxt != 0));
      chk("read_data", 64'(got), 64'(exp_q.pop_front()));
    end
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.din   = 1'b0;
  endtask

  task automatic err_chk(input string tag, input int base, input int exp_delta, input int exp_cyc);
    step();
    step();
    chk({tag, "_count"}, 64'(err_cnt - base), 64'(exp_delta));
    if (exp_cyc >= 0) chk({tag, "_cycle"}, 64'(last_err_cyc), 64'(exp_cyc));
  endtask

  initial begin
    int c0;
    int eb;
    bus_if.wr_en  = 1'b0;
    bus_if.rd_en  = 1'b0;
    bus_if.din    = 1'b0;
    bus_if.stat_d = '0;
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;

    repeat (3) step();
    chk("rst_dout", 64'(bus_if.dout), 64'(0));
    chk("rst_busy", 64'(bus_if.busy), 64'(0));
    chk("rst_err",  64'(bus_if.err),  64'(0));
    chk("rst_regq", 64'(bus_if.reg_q), 64'(0));
    rst_n = 1'b1;
    step();

    // Basic read / write / read
    eb = err_cnt;
    frame(1'b0, 8'h34, 8'h00, 1'b0, 0, -1, 1'b0, c0);
    frame(1'b1, 8'h34, 8'hFF, 1'b0, 0, -1, 1'b0, c0);
    frame(1'b0, 8'h34, 8'h00, 1'b0, 0, -1, 1'b0, c0);
    err_chk("t1_err", eb, 0, -1);

    // Read-only entry returns live status, writes ignored silently
    bus_if.stat_d[39:32] = 8'h33;
    eb = err_cnt;
    frame(1'b0, 8'h55, 8'h00, 1'b0, 0, -1, 1'b0, c0);
    frame(1'b1, 8'h55, 8'hAA, 1'b0, 0, -1, 1'b0, c0);
    frame(1'b0, 8'h55, 8'h00, 1'b0, 0, -1, 1'b0, c0);
    err_chk("t2_err", eb, 0, -1);

    // Back-to-back frames
    eb = err_cnt;
    frame(1'b1, 8'h34, 8'hDD, 1'b0, 1, -1, 1'b0, c0);
    frame(1'b1, 8'h78, 8'h81, 1'b1, 0, -1, 1'b0, c0);
    frame(1'b0, 8'h34, 8'h00, 1'b0, 0, -1, 1'b0, c0);
    frame(1'b0, 8'h78, 8'h00, 1'b0, 0, -1, 1'b0, c0);
    frame(1'b1, 8'hA1, 8'h10, 1'b0, 2, -1, 1'b0, c0);
    frame(1'b0, 8'hA1, 8'h00, 1'b1, 0, -1, 1'b0, c0);
    frame(1'b0, 8'h34, 8'h00, 1'b0, 2, -1, 1'b0, c0);
    frame(1'b0, 8'h78, 8'h00, 1'b1, 0, -1, 1'b0, c0);
    err_chk("t3_err", eb, 0, -1);

    // Stray strobe mid-frame
    eb = err_cnt;
    frame(1'b1, 8'h06, 8'h55, 1'b0, 0, 4, 1'b0, c0);
    err_chk("t4_err", eb, 1, c0 + 5);
    frame(1'b0, 8'h06, 8'h00, 1'b0, 0, -1, 1'b0, c0);

    // Unmapped address
    eb = err_cnt;
    frame(1'b1, 8'h99, 8'h12, 1'b0, 0, -1, 1'b0, c0);
    err_chk("t5w_err", eb, 1, c0 + 16);
    eb = err_cnt;
    frame(1'b0, 8'h99, 8'h00, 1'b0, 0, -1, 1'b0, c0);
    err_chk("t5r_err", eb, 1, c0 + 9);

    // Both strobes together: write proceeds, error flagged
    eb = err_cnt;
    frame(1'b1, 8'h78, 8'h5A, 1'b0, 0, -1, 1'b1, c0);
    err_chk("both_err", eb, 1, -1);
    frame(1'b0, 8'h78, 8'h00, 1'b0, 0, -1, 1'b0, c0);

    // Reset in the middle of a write frame
    eb = err_cnt;
    bus_if.wr_en = 1'b1;
    step();
    bus_if.wr_en = 1'b0;
    for (int k = 7; k >= 0; k--) begin bus_if.din = 1'(8'h06 >> k); step(); end
    for (int k = 7; k >= 4; k--) begin bus_if.din = 1'(8'hEE >> k); step(); end
    bus_if.din = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
    chk("t6_busy", 64'(bus_if.busy), 64'(0));
    chk("t6_dout", 64'(bus_if.dout), 64'(0));
    chk("t6_regq", 64'(bus_if.reg_q), 64'(model_q()));
    step();
    step();
    rst_n = 1'b1;
    step();
    frame(1'b0, 8'h06, 8'h00, 1'b0, 0, -1, 1'b0, c0);
    frame(1'b0, 8'h34, 8'h00, 1'b0, 0, -1, 1'b0, c0);
    err_chk("t6_err", eb, 0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
